// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage; owns the PC, fetches words over req/ack, buffers {inst, pc} for IF/ID.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   mem_req_o/mem_addr_o  fetch request and word address (held until mem_ack_i)
//   mem_ack_i/mem_data_i  transfer completion and returned instruction
//   stall_i               downstream hold; head entry is not consumed
//   branch_en_i/_target_i redirect pulse and new PC; flushes buffer and wrong-path data
//   if_inst_o/if_PC_o     head entry, all-zero when if_valid_o=0
//   if_valid_o            head entry valid
//
// Build option: IF_FETCH_BUF2_EN selects a two-entry buffer for full-rate streaming;
// without it a single holding register is used.
module if_fetch #(
    parameter int              INST_W   = 16,
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_data_i,
    input  logic              stall_i,
    input  logic              branch_en_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [INST_W-1:0] if_inst_o,
    output logic [ADDR_W-1:0] if_PC_o,
    output logic              if_valid_o
);
`ifdef IF_FETCH_BUF2_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int CW = $clog2(D + 1);

    typedef enum logic {FETCH, DISCARD} state_t;

    state_t            r_state, w_state_nx;
    logic              r_req, w_req_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [ADDR_W-1:0] r_pc, w_pc_nx;
    logic [CW-1:0]     r_count, w_count_nx;
    logic [INST_W-1:0] r_inst [D];
    logic [ADDR_W-1:0] r_ipc  [D];

    logic              w_ack, w_valid, w_pop, w_wr, w_pend;
    logic [CW-1:0]     w_fill, w_widx;

    assign w_ack   = r_req & mem_ack_i;
    assign w_pend  = r_req & ~mem_ack_i;
    assign w_valid = r_count != '0;
    assign w_pop   = w_valid & ~stall_i & ~branch_en_i;
    assign w_wr    = w_ack & (r_state == FETCH) & ~branch_en_i;
    assign w_fill  = r_count + CW'(w_wr) - CW'(w_pop);
    assign w_widx  = r_count - CW'(w_pop);

    assign mem_req_o  = r_req;
    assign mem_addr_o = r_addr;
    assign if_valid_o = w_valid;
    assign if_inst_o  = w_valid ? r_inst[0] : '0;
    assign if_PC_o    = w_valid ? r_ipc[0] : '0;

    always_comb begin
        w_state_nx = r_state;
        w_req_nx   = r_req;
        w_addr_nx  = r_addr;
        w_pc_nx    = r_pc;
        w_count_nx = w_fill;
        if (branch_en_i) begin
            // A request still in flight must complete at its old address; its data is then dropped.
            w_count_nx = '0;
            w_pc_nx    = branch_target_i;
            w_req_nx   = 1'b1;
            w_state_nx = w_pend ? DISCARD : FETCH;
            w_addr_nx  = w_pend ? r_addr : branch_target_i;
        end else if (r_state == DISCARD) begin
            w_state_nx = w_ack ? FETCH : DISCARD;
            w_addr_nx  = w_ack ? r_pc : r_addr;
        end else begin
            w_pc_nx   = w_ack ? r_pc + ADDR_W'(1) : r_pc;
            w_addr_nx = w_pc_nx;
            w_req_nx  = w_pend | (w_fill < CW'(D));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= FETCH;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_pc    <= RESET_PC;
            r_count <= '0;
        end else begin
            r_state <= w_state_nx;
            r_req   <= w_req_nx;
            r_addr  <= w_addr_nx;
            r_pc    <= w_pc_nx;
            r_count <= w_count_nx;
        end
    end

    // Entry 0 is the head; a pop shifts the queue down and a write lands behind the survivors.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < D; i++) begin
            if (w_wr && w_widx == CW'(i)) begin
                r_inst[i] <= mem_data_i;
                r_ipc[i]  <= r_addr;
            end else if (w_pop && i < D - 1) begin
                r_inst[i] <= r_inst[(i + 1) % D];
                r_ipc[i]  <= r_ipc[(i + 1) % D];
            end
        end
    end
endmodule
